// File: rtl/split_reduce_seq.sv
// Order-independent, checked AND-reduction of NUM_SPLITS serialised split results.
// Optional macro SPLIT_REDUCE_EARLY_EXIT_EN: finish the evaluation on the first accepted zero.
module split_reduce_seq #(
    parameter int NUM_SPLITS = 150,
    parameter int IDX_W      = $clog2(NUM_SPLITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_x,
    output logic             busy,
    output logic             done,
    output logic             x,
    output logic             fail_valid,
    output logic [IDX_W-1:0] fail_idx,
    output logic             err
);

    localparam int CNT_W = $clog2(NUM_SPLITS + 1);
    localparam logic [IDX_W:0]   IDX_LIMIT = (IDX_W + 1)'(NUM_SPLITS);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_SPLITS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nxt;
    logic [NUM_SPLITS-1:0] bitmap_r;
    logic [CNT_W-1:0]      count_r;
    logic                  in_ready_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  x_r;
    logic                  fail_valid_r;
    logic [IDX_W-1:0]      fail_idx_r;
    logic                  err_r;

    logic xfer_s;
    logic in_range_s;
    logic dup_s;
    logic accept_s;
    logic drop_s;
    logic clear_s;
    logic first_fail_s;

    // Transfer classification; the bitmap is only read for in-range indices.
    always_comb begin
        xfer_s     = in_valid & in_ready_r;
        in_range_s = ({1'b0, in_idx} < IDX_LIMIT);
        if (in_range_s) begin
            dup_s = bitmap_r[in_idx];
        end else begin
            dup_s = 1'b0;
        end
        accept_s     = xfer_s & in_range_s & ~dup_s;
        drop_s       = xfer_s & ~accept_s;
        clear_s      = start & ((state_r == IDLE) | (state_r == DONE));
        first_fail_s = accept_s & ~in_x & (~fail_valid_r | (in_idx < fail_idx_r));
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt = COLLECT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            COLLECT: begin
                if (accept_s && (count_r == LAST_CNT)) begin
                    state_nxt = DONE;
`ifdef SPLIT_REDUCE_EARLY_EXIT_EN
                end else if (accept_s && !in_x) begin
                    state_nxt = DONE;
`endif
                end else begin
                    state_nxt = COLLECT;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = COLLECT;
                end else begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, registered status decodes and the accumulation datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            bitmap_r     <= '0;
            count_r      <= '0;
            in_ready_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            x_r          <= 1'b1;
            fail_valid_r <= 1'b0;
            fail_idx_r   <= '0;
            err_r        <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            in_ready_r <= (state_nxt == COLLECT);
            busy_r     <= (state_nxt == COLLECT);
            done_r     <= (state_nxt == DONE);
            if (clear_s) begin
                bitmap_r     <= '0;
                count_r      <= '0;
                x_r          <= 1'b1;
                fail_valid_r <= 1'b0;
                fail_idx_r   <= '0;
                err_r        <= 1'b0;
            end else begin
                if (accept_s) begin
                    bitmap_r[in_idx] <= 1'b1;
                    count_r          <= count_r + CNT_W'(1);
                    x_r              <= x_r & in_x;
                end
                if (first_fail_s) begin
                    fail_idx_r   <= in_idx;
                    fail_valid_r <= 1'b1;
                end
                if (drop_s) begin
                    err_r <= 1'b1;
                end
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign x          = x_r;
    assign fail_valid = fail_valid_r;
    assign fail_idx   = fail_idx_r;
    assign err        = err_r;

endmodule

// File: tb/tb_split_reduce_seq.sv
// Scoreboard bench for split_reduce_seq: drivers push hand-computed final results,
// a monitor pops and compares them whenever done rises.
module tb_split_reduce_seq;

    localparam int N  = 150;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_idx;
    logic          in_x;
    logic          busy;
    logic          done;
    logic          x;
    logic          fail_valid;
    logic [IW-1:0] fail_idx;
    logic          err;

    typedef struct {
        logic          x;
        logic          fv;
        logic [IW-1:0] fi;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   last_cyc  = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    logic done_q    = 1'b0;
    logic acc;
    int   n_acc;

    split_reduce_seq #(.NUM_SPLITS(N), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_x(in_x), .busy(busy), .done(done), .x(x),
        .fail_valid(fail_valid), .fail_idx(fail_idx), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic ex, input logic efv, input int efi, input logic eerr);
        exp_t e;
        e.x   = ex;
        e.fv  = efv;
        e.fi  = IW'(efi);
        e.err = eerr;
        e.cyc = last_cyc;
        sb.push_back(e);
    endtask

    // One beat: present for one cycle, report whether in_ready was high at the edge.
    task automatic beat(input int idx, input logic xv, output logic a);
        in_valid = 1'b1;
        in_idx   = IW'(idx);
        in_x     = xv;
        @(negedge clk) a = in_ready;
        @(posedge clk) #1;
        in_valid = 1'b0;
        last_cyc = cyc;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk) #1;
    endtask

    // Monitor: every rising done must match the oldest expected result.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1 && done_q === 1'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("final_x", x, e.x);
                check("final_fail_valid", fail_valid, e.fv);
                check("final_fail_idx", fail_idx, e.fi);
                check("final_err", err, e.err);
            end
        end
        done_q = done;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_idx = '0; in_x = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_x", x, 1);
        check("rst_fail_valid", fail_valid, 0);
        check("rst_fail_idx", fail_idx, 0);
        check("rst_err", err, 0);

        // In-order, all pass
        do_start();
        check("t1_in_ready_after_start", in_ready, 1);
        n_acc = 0;
        for (int i = 0; i < N; i++) begin
            beat(i, 1'b1, acc);
            n_acc += int'(acc);
        end
        check("t1_accepted", n_acc, N);
        push(1'b1, 1'b0, 0, 1'b0);
        idle(3);

        // Reverse order, zeros at 97 and 12
        do_start();
        for (int i = N - 1; i >= 0; i--) begin
            beat(i, (i == 97 || i == 12) ? 1'b0 : 1'b1, acc);
`ifdef SPLIT_REDUCE_EARLY_EXIT_EN
            if (i == 97) break;
`endif
        end
`ifdef SPLIT_REDUCE_EARLY_EXIT_EN
        push(1'b0, 1'b1, 97, 1'b0);
        @(negedge clk);
        check("t2_in_ready_done", in_ready, 0);
        @(posedge clk) #1;
`else
        push(1'b0, 1'b1, 12, 1'b0);
`endif
        idle(3);

        // Duplicate and out-of-range indices are dropped
        do_start();
        beat(5, 1'b1, acc);
        check("t3_err_clean", err, 0);
        beat(5, 1'b1, acc);
        check("t3_err_dup", err, 1);
        beat(200, 1'b0, acc);
        check("t3_x_after_oor", x, 1);
        for (int i = 0; i < N; i++) begin
            if (i != 5) beat(i, 1'b1, acc);
        end
        push(1'b1, 1'b0, 0, 1'b1);
        idle(3);

        // Random gaps and a start pulse mid-collection
        do_start();
        for (int i = 0; i < N; i++) begin
            idle($urandom_range(0, 2));
            if (i == 40) start = 1'b1;
            beat(i, (i == N - 1) ? 1'b0 : 1'b1, acc);
            start = 1'b0;
            if (i == 40) check("t4_busy_after_start", busy, 1);
        end
        push(1'b0, 1'b1, N - 1, 1'b0);
        idle(3);

        // Reset after 70 accepted results
        do_start();
        for (int i = 0; i < 70; i++) beat(i, 1'b1, acc);
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        check("t5_in_ready", in_ready, 0);
        check("t5_x", x, 1);
        check("t5_done", done, 0);
        check("t5_busy", busy, 0);
        do_start();
        for (int i = 0; i < N; i++) beat(i, 1'b1, acc);
        push(1'b1, 1'b0, 0, 1'b0);
        idle(3);

        // start together with in_valid while in DONE
        check("t6_done_held", done, 1);
        start = 1'b1; in_valid = 1'b1; in_idx = '0; in_x = 1'b0;
        @(posedge clk) #1;
        start = 1'b0; in_valid = 1'b0;
        check("t6_in_ready", in_ready, 1);
        check("t6_busy", busy, 1);
        check("t6_done", done, 0);
        check("t6_x", x, 1);
        check("t6_fail_valid", fail_valid, 0);
        for (int i = 0; i < N; i++) beat(i, 1'b1, acc);
        push(1'b1, 1'b0, 0, 1'b0);
        idle(4);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/split_reduce_seq.md
# split_reduce_seq

Sequential conjunction collector for split constraint results. It accepts the 1-bit `x` results of NUM_SPLITS split modules one at a time over a valid/ready stream, in any order. It reports the global AND, the lowest-indexed failing split and any protocol errors. It sits between the split modules' result serialiser and the solver top-level, replacing a flat NUM_SPLITS-input AND with a bounded-width, order-independent, checked accumulation.

## Interface
Parameters:
- NUM_SPLITS, 150, number of split results expected per evaluation (>= 2)
- IDX_W, $clog2(NUM_SPLITS), width of split index fields

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a new evaluation (sampled in IDLE or DONE only)
- in_valid  in  1  result present on in_idx/in_x
- in_ready  out  1  block can accept a result this cycle
- in_idx  in  IDX_W  index of the split producing in_x
- in_x  in  1  that split's output
- busy  out  1  evaluation in progress (COLLECT)
- done  out  1  all NUM_SPLITS results received (or early exit); held until next start
- x  out  1  running/final AND of accepted results
- fail_valid  out  1  at least one accepted result was 0
- fail_idx  out  IDX_W  lowest index whose accepted result was 0
- err  out  1  sticky: duplicate or out-of-range index was offered and dropped

## Operation
- States: IDLE, COLLECT, DONE.
- IDLE/DONE + start -> COLLECT. Entry clears the received bitmap (NUM_SPLITS bits) and the count. It sets x=1, fail_valid=0, fail_idx=0, err=0 and done=0.
- COLLECT: in_ready=1. A transfer occurs when in_valid && in_ready.
  - in_idx >= NUM_SPLITS, or the bitmap bit already set: result dropped, err<=1, count unchanged.
  - Otherwise: bitmap[in_idx]<=1, count<=count+1, x<=x & in_x.
  - If in_x==0 and (!fail_valid or in_idx < fail_idx): fail_idx<=in_idx, fail_valid<=1.
- COLLECT -> DONE when an accepted transfer brings count to NUM_SPLITS.
- start while in COLLECT is ignored.
- DONE: in_ready=0, done=1. Outputs hold until start or rst.
- The count register is $clog2(NUM_SPLITS+1) bits and never wraps: at most NUM_SPLITS distinct acceptances are possible.

## Timing
- Reset values: in_ready=0, busy=0, done=0, x=1, fail_valid=0, fail_idx=0, err=0, state=IDLE, bitmap=0, count=0.
- in_ready and busy are registered state decodes. in_ready rises the cycle after start is sampled.
- x, fail_*, err update the cycle after the transfer edge.
- done rises the cycle after the final accepted transfer. The final x is valid in that same cycle.
- Minimum evaluation: 1 start cycle + NUM_SPLITS transfer cycles + 1 cycle to done.
- Back-to-back transfers are accepted every cycle. No bubbles are required.
- rst mid-evaluation: next cycle all outputs are at reset values and the partial evaluation is discarded.
- start in DONE: the clear and the transition to COLLECT occur in one edge.

## Configuration
- SPLIT_REDUCE_EARLY_EXIT_EN defined: an accepted transfer with in_x==0 moves COLLECT -> DONE immediately.
  - x=0, fail_valid=1, fail_idx=that index.
  - Remaining results are not requested (in_ready=0 in DONE).
- SPLIT_REDUCE_EARLY_EXIT_EN undefined: all NUM_SPLITS results are always collected. fail_idx reports the lowest failing index overall.

## Test plan
- NUM_SPLITS=150, start, indices 0..149 in order, all in_x=1 -> done rises the cycle after the 150th transfer, x=1, fail_valid=0, err=0.
- Reverse order 149..0, in_x=0 at idx 97 and idx 12 -> without EARLY_EXIT: done, x=0, fail_valid=1, fail_idx=12. With EARLY_EXIT: done after the idx-97 transfer (53rd accepted), fail_idx=97.
- Offer idx 5 twice, then idx 200 -> both dropped, err=1, count unchanged, done only after all 150 distinct indices.
- in_valid toggling with random gaps, plus start pulsed mid-COLLECT -> start ignored, result identical to the gap-free run.
- rst asserted after 70 accepted results -> next cycle in_ready=0, x=1, done=0. A fresh start then requires a full 150 results.
- In DONE, start and in_valid asserted together -> the in_valid beat is not accepted. The bitmap is cleared and in_ready=1 on the next cycle.
